ibex_branch_resolve: RTL

Execute-side counterpart to the static fetch-stage branch predictor. It queues each prediction issued at fetch and, when the execute stage resolves the matching branch or jump, compares the actual outcome with the prediction. On a mismatch it issues a registered one-cycle redirect with the correct PC and discards all younger queued predictions. It also keeps saturating branch and mispredict counters for the performance-counter block.

---
 rtl/ibex_branch_resolve_pkg.sv | 20 ++
 rtl/ibex_branch_resolve_fifo.sv | 69 ++++++
 rtl/ibex_branch_resolve.sv | 109 ++++++++++
 3 files changed

// File: rtl/ibex_branch_resolve_pkg.sv
// Shared types and constants for the execute-side branch prediction checker.
// Holds the queued prediction record and the fall-through increments.
package ibex_branch_resolve_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        compressed;
    logic        taken;
    logic [31:0] target;
  } bp_entry_t;

  localparam logic [31:0] BP_FALLTHRU_INC_C  = 32'd4;
  localparam logic [31:0] BP_FALLTHRU_CINC_C = 32'd2;

  // Sequential PC after a branch/jump; wraps modulo 2^32.
  function automatic logic [31:0] bp_fallthru(input logic [31:0] pc, input logic compressed);
    return pc + (compressed ? BP_FALLTHRU_CINC_C : BP_FALLTHRU_INC_C);
  endfunction

endpackage

// File: rtl/ibex_branch_resolve_fifo.sv
// In-order prediction queue with a clear that empties it and drops any same-cycle push/pop.
// Pointers carry one extra bit so full and empty can be told apart.
module ibex_branch_resolve_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic             pushOk, popOk;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AddrW] != rdPtr_q[AddrW]) &&
                   (wrPtr_q[AddrW-1:0] == rdPtr_q[AddrW-1:0]);
  assign head_o  = mem_q[rdPtr_q[AddrW-1:0]];

  assign pushOk = push_i & ~full_o & ~clear_i;
  assign popOk  = pop_i & ~empty_o & ~clear_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + PtrW'(1);
      if (popOk)  rdPtr_d = rdPtr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (pushOk) mem_q[wrPtr_q[AddrW-1:0]] <= data_i;
  end

  DepthPow2: assert property (@(posedge clk_i)
    (Depth >= 2) && ((Depth & (Depth - 1)) == 0))
    else $error("Depth must be a power of two and at least 2");

  NoPopEmpty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop_i |-> !empty_o)
    else $error("pop while fifo empty");

endmodule

// File: rtl/ibex_branch_resolve.sv
// Checks each fetch-stage prediction against the execute outcome, raises a registered
// redirect on mismatch and keeps saturating branch/mispredict counters.
module ibex_branch_resolve
  import ibex_branch_resolve_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pred_valid_i,
  output logic                pred_ready_o,
  input  logic [31:0]         pred_pc_i,
  input  logic                pred_compressed_i,
  input  logic                pred_taken_i,
  input  logic [31:0]         pred_target_i,
  input  logic                res_valid_i,
  output logic                res_ready_o,
  input  logic                res_taken_i,
  input  logic [31:0]         res_target_i,
  input  logic                flush_i,
  output logic                mispredict_o,
  output logic [31:0]         redirect_pc_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] cnt_branch_o,
  output logic [CntWidth-1:0] cnt_mispredict_o
);

  localparam int unsigned EntryW = $bits(bp_entry_t);
  localparam logic [CntWidth-1:0] CntOneC = CntWidth'(1);

  bp_entry_t           pushEntry, headEntry;
  logic                full, empty;
  logic                doPush, doPop, resolveFire, misDetect, misFire, fifoClear;
  logic [31:0]         correctPc;
  logic                mispredict_q;
  logic [31:0]         redirectPc_q;
  logic [CntWidth-1:0] cntBranch_q, cntBranch_d;
  logic [CntWidth-1:0] cntMis_q, cntMis_d;

  assign pushEntry = '{pc: pred_pc_i, compressed: pred_compressed_i,
                       taken: pred_taken_i, target: pred_target_i};

  assign doPush      = pred_valid_i & ~full;
  assign doPop       = res_valid_i & ~empty;
  assign resolveFire = doPop & ~flush_i;

  assign misDetect = (headEntry.taken != res_taken_i) ||
                     (headEntry.taken && res_taken_i && (headEntry.target != res_target_i));
  assign correctPc = res_taken_i ? res_target_i
                                 : bp_fallthru(headEntry.pc, headEntry.compressed);

  // A mispredict wipes the younger wrong-path entries along with any same-cycle push.
  assign misFire   = resolveFire & misDetect;
  assign fifoClear = flush_i | misFire;

  ibex_branch_resolve_fifo #(
    .Depth (Depth),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (doPush),
    .pop_i   (doPop),
    .clear_i (fifoClear),
    .data_i  (pushEntry),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (headEntry)
  );

  always_comb begin
    cntBranch_d = cntBranch_q;
    cntMis_d    = cntMis_q;
    if (resolveFire && (cntBranch_q != '1)) cntBranch_d = cntBranch_q + CntOneC;
    if (misFire && (cntMis_q != '1))        cntMis_d    = cntMis_q + CntOneC;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mispredict_q <= 1'b0;
      redirectPc_q <= '0;
      cntBranch_q  <= '0;
      cntMis_q     <= '0;
    end else begin
      mispredict_q <= misFire;
      if (misFire) redirectPc_q <= correctPc;
      cntBranch_q  <= cntBranch_d;
      cntMis_q     <= cntMis_d;
    end
  end

  assign pred_ready_o     = ~full;
  assign res_ready_o      = ~empty;
  assign empty_o          = empty;
  assign mispredict_o     = mispredict_q;
  assign redirect_pc_o    = redirectPc_q;
  assign cnt_branch_o     = cntBranch_q;
  assign cnt_mispredict_o = cntMis_q;

  ResolveNotEmpty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    res_valid_i |-> !empty)
    else $error("res_valid_i asserted with no outstanding prediction");

  NoBackToBackMispredict: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mispredict_q |=> !mispredict_q)
    else $error("mispredict_o high for two consecutive cycles");

endmodule
